// File: rtl/vram_arb_pkg.sv
// Shared PPU definitions: VRAM widths, request-buffer record, read-owner tag
// and the default sizing of the VRAM arbiter.
package vram_arb_pkg;

  localparam int DEF_DEPTH        = 4;
  localparam int DEF_STARVE_LIMIT = 8;
  localparam int VRAM_AW          = 11;
  localparam int VRAM_DW          = 8;
  localparam int REQ_W            = 1 + VRAM_AW + VRAM_DW;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_REND = 2'd1,
    OWN_CPU  = 2'd2
  } vram_owner_t;

  typedef struct packed {
    logic               we;
    logic [VRAM_AW-1:0] addr;
    logic [VRAM_DW-1:0] data;
  } vram_req_t;

  function automatic vram_req_t pack_req(input logic               we,
                                         input logic [VRAM_AW-1:0] addr,
                                         input logic [VRAM_DW-1:0] data);
    vram_req_t r;
    r.we   = we;
    r.addr = addr;
    r.data = data;
    return r;
  endfunction

endpackage

// File: rtl/vram_arb_if.sv
// Bus bundle between the VRAM arbiter, its two requesters and the VRAM macro.
// master = requester/memory side, slave = arbiter side.
interface vram_arb_if;
  import vram_arb_pkg::*;

  logic               ppu_clk_en;
  logic               rendering;
  logic               rend_req;
  logic [VRAM_AW-1:0] rend_addr;
  logic               rend_gnt;
  logic [VRAM_DW-1:0] rend_rd_data;
  logic               rend_rd_valid;
  logic               cpu_req;
  logic               cpu_we;
  logic [VRAM_AW-1:0] cpu_addr;
  logic [VRAM_DW-1:0] cpu_wr_data;
  logic               cpu_rdy;
  logic [VRAM_DW-1:0] cpu_rd_data;
  logic               cpu_rd_valid;
  logic [VRAM_AW-1:0] vram_addr;
  logic               vram_re;
  logic               vram_we;
  logic [VRAM_DW-1:0] vram_wr_data;
  logic [VRAM_DW-1:0] vram_rd_data;

  modport master (
    output ppu_clk_en, rendering, rend_req, rend_addr,
           cpu_req, cpu_we, cpu_addr, cpu_wr_data, vram_rd_data,
    input  rend_gnt, rend_rd_data, rend_rd_valid, cpu_rdy, cpu_rd_data,
           cpu_rd_valid, vram_addr, vram_re, vram_we, vram_wr_data
  );

  modport slave (
    input  ppu_clk_en, rendering, rend_req, rend_addr,
           cpu_req, cpu_we, cpu_addr, cpu_wr_data, vram_rd_data,
    output rend_gnt, rend_rd_data, rend_rd_valid, cpu_rdy, cpu_rd_data,
           cpu_rd_valid, vram_addr, vram_re, vram_we, vram_wr_data
  );

endinterface

// File: rtl/vram_req_fifo.sv
// In-order CPU request buffer: power-of-two depth, flushed by synchronous reset.
module vram_req_fifo
  import vram_arb_pkg::*;
#(
  parameter  int DEPTH = DEF_DEPTH,
  parameter  int WIDTH = REQ_W,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = AW + 1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] din_i,
  output logic [WIDTH-1:0] dout_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [CW-1:0]    count_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q;
  logic [AW-1:0]    rd_ptr_q;
  logic [CW-1:0]    count_q;
  logic [CW-1:0]    count_d;
  logic             push_s;
  logic             pop_s;

  assign full_o  = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == {CW{1'b0}});
  assign count_o = count_q;
  assign dout_o  = mem_q[rd_ptr_q];
  assign push_s  = push_i && !full_o;
  assign pop_s   = pop_i && !empty_o;

  always_comb begin
    case ({push_s, pop_s})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= {AW{1'b0}};
      rd_ptr_q <= {AW{1'b0}};
      count_q  <= {CW{1'b0}};
    end else begin
      if (push_s) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop_s)  rd_ptr_q <= rd_ptr_q + AW'(1);
      count_q <= count_d;
    end
  end

  // Storage needs no reset: pointers and count define what is valid.
  always_ff @(posedge clk_i) begin
    if (push_s) mem_q[wr_ptr_q] <= din_i;
  end

endmodule

// File: rtl/vram_arb.sv
// VRAM arbiter between the PPU renderer and buffered CPU accesses, with
// starvation override and a two-stage owner-tagged read-return pipeline.
module vram_arb
  import vram_arb_pkg::*;
#(
  parameter int DEPTH        = DEF_DEPTH,
  parameter int STARVE_LIMIT = DEF_STARVE_LIMIT
) (
  input logic        clk,
  input logic        rst,
  vram_arb_if.slave  bus
);

  localparam int CW    = $clog2(DEPTH) + 1;
  localparam int AGE_W = $clog2(STARVE_LIMIT) + 1;
  localparam logic [AGE_W-1:0] AGE_MAX   = {AGE_W{1'b1}};
  localparam logic [AGE_W-1:0] STARVE_TH = AGE_W'(STARVE_LIMIT);
  localparam logic [CW-1:0]    DEPTH_C   = CW'(DEPTH);

  logic                fifo_full_s, fifo_empty_s;
  logic [CW-1:0]       fifo_count_s, cnt_next_s;
  logic [REQ_W-1:0]    head_raw_s;
  vram_req_t           head_s, push_data_s;
  logic                push_s, sel_cpu_s, sel_rend_s, starve_s;
  logic                cpu_rdy_q, cpu_rdy_d;
  logic [AGE_W-1:0]    age_q, age_d;

  logic [VRAM_AW-1:0]  vram_addr_q, vram_addr_d;
  logic                vram_re_q, vram_re_d, vram_we_q, vram_we_d;
  logic [VRAM_DW-1:0]  vram_wr_data_q, vram_wr_data_d;
  logic                rend_gnt_q, rend_gnt_d;
  vram_owner_t         own_iss_q, own_iss_d, own_ret_q;
  logic [VRAM_DW-1:0]  rend_rd_data_q, rend_rd_data_d, cpu_rd_data_q, cpu_rd_data_d;
  logic                rend_rd_valid_q, rend_rd_valid_d, cpu_rd_valid_q, cpu_rd_valid_d;

  assign push_data_s = pack_req(bus.cpu_we, bus.cpu_addr, bus.cpu_wr_data);
  assign head_s      = vram_req_t'(head_raw_s);
  assign push_s      = bus.cpu_req && cpu_rdy_q && !fifo_full_s;
  assign starve_s    = (age_q >= STARVE_TH);

  vram_req_fifo #(.DEPTH(DEPTH), .WIDTH(REQ_W)) u_fifo (
    .clk_i   (clk),
    .rst_i   (rst),
    .push_i  (push_s),
    .pop_i   (sel_cpu_s),
    .din_i   (push_data_s),
    .dout_o  (head_raw_s),
    .full_o  (fifo_full_s),
    .empty_o (fifo_empty_s),
    .count_o (fifo_count_s)
  );

  always_comb begin
    sel_cpu_s  = 1'b0;
    sel_rend_s = 1'b0;
    if (bus.ppu_clk_en) begin
      if (!fifo_empty_s && (starve_s || !(bus.rendering && bus.rend_req))) begin
        sel_cpu_s = 1'b1;
      end else if (bus.rend_req) begin
        sel_rend_s = 1'b1;
      end else begin
        sel_cpu_s  = 1'b0;
        sel_rend_s = 1'b0;
      end
    end else begin
      sel_cpu_s  = 1'b0;
      sel_rend_s = 1'b0;
    end
  end

  // Ready is registered from the post-edge count, so a pop only frees a slot next cycle.
  always_comb begin
    case ({push_s, sel_cpu_s})
      2'b10:   cnt_next_s = fifo_count_s + CW'(1);
      2'b01:   cnt_next_s = fifo_count_s - CW'(1);
      default: cnt_next_s = fifo_count_s;
    endcase
    cpu_rdy_d = (cnt_next_s < DEPTH_C);
  end

  always_comb begin
    age_d = age_q;
    if (fifo_empty_s || sel_cpu_s) begin
      age_d = {AGE_W{1'b0}};
    end else if (bus.ppu_clk_en) begin
      if (age_q != AGE_MAX) age_d = age_q + AGE_W'(1);
      else                  age_d = age_q;
    end else begin
      age_d = age_q;
    end
  end

  always_comb begin
    vram_addr_d    = {VRAM_AW{1'b0}};
    vram_re_d      = 1'b0;
    vram_we_d      = 1'b0;
    vram_wr_data_d = {VRAM_DW{1'b0}};
    rend_gnt_d     = 1'b0;
    own_iss_d      = OWN_NONE;
    if (sel_cpu_s) begin
      vram_addr_d = head_s.addr;
      vram_we_d   = head_s.we;
      vram_re_d   = !head_s.we;
      if (head_s.we) vram_wr_data_d = head_s.data;
      else           own_iss_d      = OWN_CPU;
    end else if (sel_rend_s) begin
      vram_addr_d = bus.rend_addr;
      vram_re_d   = 1'b1;
      rend_gnt_d  = 1'b1;
      own_iss_d   = OWN_REND;
    end else begin
      own_iss_d   = OWN_NONE;
    end
  end

  always_comb begin
    rend_rd_data_d  = rend_rd_data_q;
    cpu_rd_data_d   = cpu_rd_data_q;
    rend_rd_valid_d = 1'b0;
    cpu_rd_valid_d  = 1'b0;
    case (own_ret_q)
      OWN_REND: begin
        rend_rd_data_d  = bus.vram_rd_data;
        rend_rd_valid_d = 1'b1;
      end
      OWN_CPU: begin
        cpu_rd_data_d  = bus.vram_rd_data;
        cpu_rd_valid_d = 1'b1;
      end
      default: begin
        rend_rd_valid_d = 1'b0;
        cpu_rd_valid_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cpu_rdy_q       <= 1'b0;
      age_q           <= {AGE_W{1'b0}};
      vram_addr_q     <= {VRAM_AW{1'b0}};
      vram_re_q       <= 1'b0;
      vram_we_q       <= 1'b0;
      vram_wr_data_q  <= {VRAM_DW{1'b0}};
      rend_gnt_q      <= 1'b0;
      own_iss_q       <= OWN_NONE;
      own_ret_q       <= OWN_NONE;
      rend_rd_data_q  <= {VRAM_DW{1'b0}};
      cpu_rd_data_q   <= {VRAM_DW{1'b0}};
      rend_rd_valid_q <= 1'b0;
      cpu_rd_valid_q  <= 1'b0;
    end else begin
      cpu_rdy_q       <= cpu_rdy_d;
      age_q           <= age_d;
      vram_addr_q     <= vram_addr_d;
      vram_re_q       <= vram_re_d;
      vram_we_q       <= vram_we_d;
      vram_wr_data_q  <= vram_wr_data_d;
      rend_gnt_q      <= rend_gnt_d;
      own_iss_q       <= own_iss_d;
      own_ret_q       <= own_iss_q;
      rend_rd_data_q  <= rend_rd_data_d;
      cpu_rd_data_q   <= cpu_rd_data_d;
      rend_rd_valid_q <= rend_rd_valid_d;
      cpu_rd_valid_q  <= cpu_rd_valid_d;
    end
  end

  assign bus.cpu_rdy       = cpu_rdy_q;
  assign bus.vram_addr     = vram_addr_q;
  assign bus.vram_re       = vram_re_q;
  assign bus.vram_we       = vram_we_q;
  assign bus.vram_wr_data  = vram_wr_data_q;
  assign bus.rend_gnt      = rend_gnt_q;
  assign bus.rend_rd_data  = rend_rd_data_q;
  assign bus.rend_rd_valid = rend_rd_valid_q;
  assign bus.cpu_rd_data   = cpu_rd_data_q;
  assign bus.cpu_rd_valid  = cpu_rd_valid_q;

endmodule

// File: tb/tb_vram_arb.sv
// Directed bench for vram_arb: hand-computed expectations, synchronous-read
// VRAM model preloaded with known bytes.
module tb_vram_arb;
  import vram_arb_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] vram_mem [0:2047];
  logic [7:0] vram_rd_q;
  logic       en_hist [0:15];
  int         checks   = 0;
  int         failures = 0;

  vram_arb_if bus_if ();

  vram_arb #(.DEPTH(4), .STARVE_LIMIT(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (bus_if.vram_re) vram_rd_q <= vram_mem[bus_if.vram_addr];
  end
  assign bus_if.vram_rd_data = vram_rd_q;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic en_now;
    logic exp_v;

    for (int a = 0; a < 2048; a++) vram_mem[a] = 8'h00;
    vram_mem[11'h040] = 8'hC3;
    vram_mem[11'h010] = 8'h5C;
    for (int i = 0; i < 5; i++) vram_mem[11'h300 + i] = 8'h10 + 8'(i);
    for (int i = 0; i < 16; i++) en_hist[i] = 1'b0;

    rst = 1'b1;
    bus_if.ppu_clk_en  = 1'b0;
    bus_if.rendering   = 1'b0;
    bus_if.rend_req    = 1'b0;
    bus_if.rend_addr   = 11'h000;
    bus_if.cpu_req     = 1'b0;
    bus_if.cpu_we      = 1'b0;
    bus_if.cpu_addr    = 11'h000;
    bus_if.cpu_wr_data = 8'h00;

    // Reset state
    repeat (3) tick();
    check("rst_rdy", bus_if.cpu_rdy, 1'b0);
    check("rst_re", bus_if.vram_re, 1'b0);
    check("rst_we", bus_if.vram_we, 1'b0);
    check("rst_gnt", bus_if.rend_gnt, 1'b0);
    check("rst_cval", bus_if.cpu_rd_valid, 1'b0);
    rst = 1'b0;
    tick();
    check("rdy_after_rst", bus_if.cpu_rdy, 1'b1);

    // CPU write, rendering off
    bus_if.ppu_clk_en  = 1'b1;
    bus_if.cpu_req     = 1'b1;
    bus_if.cpu_we      = 1'b1;
    bus_if.cpu_addr    = 11'h123;
    bus_if.cpu_wr_data = 8'h5A;
    tick();
    bus_if.cpu_req = 1'b0;
    check("wr_no_bypass", bus_if.vram_we, 1'b0);
    tick();
    check("wr_we", bus_if.vram_we, 1'b1);
    check("wr_re", bus_if.vram_re, 1'b0);
    check("wr_addr", bus_if.vram_addr, 11'h123);
    check("wr_data", bus_if.vram_wr_data, 8'h5A);
    tick();
    check("wr_we_drop", bus_if.vram_we, 1'b0);
    check("wr_no_cval1", bus_if.cpu_rd_valid, 1'b0);
    tick();
    check("wr_no_cval2", bus_if.cpu_rd_valid, 1'b0);

    // CPU read, latency 2 from selection edge
    bus_if.cpu_req  = 1'b1;
    bus_if.cpu_we   = 1'b0;
    bus_if.cpu_addr = 11'h040;
    tick();
    bus_if.cpu_req = 1'b0;
    tick();
    check("rd_re", bus_if.vram_re, 1'b1);
    check("rd_addr", bus_if.vram_addr, 11'h040);
    tick();
    check("rd_cval_early", bus_if.cpu_rd_valid, 1'b0);
    tick();
    check("rd_cval", bus_if.cpu_rd_valid, 1'b1);
    check("rd_cdata", bus_if.cpu_rd_data, 8'hC3);
    check("rd_rval", bus_if.rend_rd_valid, 1'b0);
    tick();
    check("rd_cval_drop", bus_if.cpu_rd_valid, 1'b0);
    check("rd_chold", bus_if.cpu_rd_data, 8'hC3);

    // Starvation: 8 renderer grants, CPU write on the 9th
    bus_if.ppu_clk_en  = 1'b0;
    bus_if.cpu_req     = 1'b1;
    bus_if.cpu_we      = 1'b1;
    bus_if.cpu_addr    = 11'h200;
    bus_if.cpu_wr_data = 8'h77;
    tick();
    bus_if.cpu_req    = 1'b0;
    bus_if.ppu_clk_en = 1'b1;
    bus_if.rendering  = 1'b1;
    bus_if.rend_req   = 1'b1;
    bus_if.rend_addr  = 11'h010;
    for (int i = 0; i < 8; i++) begin
      tick();
      check("stv_gnt", bus_if.rend_gnt, 1'b1);
      check("stv_cpu_held", bus_if.vram_we, 1'b0);
    end
    tick();
    check("stv_cpu_we", bus_if.vram_we, 1'b1);
    check("stv_cpu_addr", bus_if.vram_addr, 11'h200);
    check("stv_cpu_data", bus_if.vram_wr_data, 8'h77);
    check("stv_no_gnt", bus_if.rend_gnt, 1'b0);
    check("stv_age0", 32'(dut.age_q), 32'd0);
    bus_if.rend_req  = 1'b0;
    bus_if.rendering = 1'b0;
    repeat (3) tick();

    // Fill with clock enable low, 5th push held, order on drain
    bus_if.ppu_clk_en = 1'b0;
    bus_if.cpu_we     = 1'b0;
    for (int i = 0; i < 4; i++) begin
      bus_if.cpu_req  = 1'b1;
      bus_if.cpu_addr = 11'h300 + 11'(i);
      check("fill_rdy", bus_if.cpu_rdy, 1'b1);
      tick();
    end
    check("full_rdy", bus_if.cpu_rdy, 1'b0);
    bus_if.cpu_addr = 11'h304;
    tick();
    check("held_rdy", bus_if.cpu_rdy, 1'b0);
    check("held_count", 32'(dut.u_fifo.count_q), 32'd4);
    check("held_no_re", bus_if.vram_re, 1'b0);
    bus_if.ppu_clk_en = 1'b1;
    for (int k = 1; k <= 7; k++) begin
      tick();
      if (k <= 5) begin
        check("drain_re", bus_if.vram_re, 1'b1);
        check("drain_addr", bus_if.vram_addr, 11'h300 + 11'(k - 1));
      end else begin
        check("drain_idle", bus_if.vram_re, 1'b0);
      end
      if (k >= 3) begin
        check("drain_cval", bus_if.cpu_rd_valid, 1'b1);
        check("drain_cdata", bus_if.cpu_rd_data, 8'h10 + 8'(k - 3));
      end
      if (k == 1) check("drain_rdy", bus_if.cpu_rdy, 1'b1);
      if (k == 2) bus_if.cpu_req = 1'b0;
    end
    repeat (2) tick();

    // Reset one clk after a CPU read issues
    bus_if.cpu_req  = 1'b1;
    bus_if.cpu_addr = 11'h040;
    tick();
    bus_if.cpu_req = 1'b0;
    tick();
    check("rr_re", bus_if.vram_re, 1'b1);
    rst = 1'b1;
    tick();
    check("rr_re0", bus_if.vram_re, 1'b0);
    check("rr_cval1", bus_if.cpu_rd_valid, 1'b0);
    rst = 1'b0;
    tick();
    check("rr_cval2", bus_if.cpu_rd_valid, 1'b0);
    check("rr_count", 32'(dut.u_fifo.count_q), 32'd0);
    check("rr_rdy", bus_if.cpu_rdy, 1'b1);
    check("rr_cdata", bus_if.cpu_rd_data, 8'h00);
    tick();
    check("rr_cval3", bus_if.cpu_rd_valid, 1'b0);

    // Clock enable every 3rd clk with renderer requesting
    bus_if.rendering = 1'b1;
    bus_if.rend_req  = 1'b1;
    bus_if.rend_addr = 11'h010;
    for (int c = 0; c < 12; c++) begin
      en_now = (c % 3 == 0);
      en_hist[c] = en_now;
      bus_if.ppu_clk_en = en_now;
      tick();
      check("ce_gnt", bus_if.rend_gnt, en_now);
      check("ce_re", bus_if.vram_re, en_now);
      exp_v = (c >= 2) ? en_hist[c - 2] : 1'b0;
      check("ce_rval", bus_if.rend_rd_valid, exp_v);
      if (exp_v) check("ce_rdata", bus_if.rend_rd_data, 8'h5C);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/vram_arb.md
VRAM_ARB -- requirements
Module: vram_arb

Interface
REQ-001 The block SHALL have parameter DEPTH, default 4: number of CPU request buffer entries (power of two, at least 2).
REQ-002 The block SHALL have parameter STARVE_LIMIT, default 8: enabled cycles a pending CPU request may lose before it gets priority.
REQ-003 The ports SHALL be as follows, one per line:
- clk  in  1  single system clock; one clock only.
- rst  in  1  reset; synchronous, active-high.
- ppu_clk_en  in  1  PPU clock enable; arbitration advances only when high.
- rendering  in  1  renderer active; when low, CPU requests are served first.
- rend_req  in  1  renderer fetch request; held until rend_gnt.
- rend_addr  in  11  renderer VRAM address.
- rend_gnt  out  1  one-clk pulse: renderer access issued.
- rend_rd_data  out  8  renderer read data.
- rend_rd_valid  out  1  one-clk pulse: rend_rd_data valid.
- cpu_req  in  1  CPU (register interface) access request.
- cpu_we  in  1  1 = write, 0 = read.
- cpu_addr  in  11  CPU VRAM address.
- cpu_wr_data  in  8  CPU write data.
- cpu_rdy  out  1  buffer can accept; a request is pushed when cpu_req and cpu_rdy.
- cpu_rd_data  out  8  CPU read data.
- cpu_rd_valid  out  1  one-clk pulse: cpu_rd_data valid.
- vram_addr  out  11  VRAM address.
- vram_re  out  1  VRAM read strobe; synchronous read, data returns 1 clk later.
- vram_we  out  1  VRAM write strobe.
- vram_wr_data  out  8  VRAM write data.
- vram_rd_data  in  8  VRAM read data.

Function
REQ-004 CPU requests SHALL be pushed as {we, addr, data} into an in-order FIFO; cpu_rdy = (count < DEPTH), computed from the registered count (a pop in the same cycle does not raise cpu_rdy).
REQ-005 Push and pop in the same clk SHALL leave count unchanged; a push into an empty FIFO is not eligible for arbitration before the next enabled cycle (no bypass).
REQ-006 At each clk with ppu_clk_en high, at most one access SHALL be selected, by this priority:
- starve (age >= STARVE_LIMIT) and FIFO non-empty -> CPU.
- rendering and rend_req -> renderer.
- FIFO non-empty -> CPU.
- rend_req -> renderer.
- otherwise none.
REQ-007 The selected access SHALL drive registered vram_addr/vram_re/vram_we/vram_wr_data for exactly one clk after the selection edge (issue cycle). All strobes SHALL be 0 otherwise.
REQ-008 rend_gnt SHALL pulse in the issue cycle of a renderer access. A CPU selection SHALL pop the FIFO head at the selection edge.
REQ-009 A registered owner tag (enum NONE, REND, CPU) SHALL follow each read through the pipeline. One clk after the issue cycle, vram_rd_data SHALL be registered into rend_rd_data or cpu_rd_data, with the matching valid pulsed for one clk.
REQ-010 Read latency from the selection edge to the valid pulse SHALL be 2 clk. Writes SHALL produce no valid pulse.
REQ-011 The age counter SHALL be saturating, clog2(STARVE_LIMIT)+1 bits wide. It increments on enabled cycles where the FIFO is non-empty and the CPU is not selected. It clears on CPU selection or when the FIFO is empty.
REQ-012 Renderer accesses SHALL always be reads; rend_req while rendering is low is still served, at lower priority.
REQ-013 rd_data outputs SHALL hold their last value between valid pulses.
REQ-014 With ppu_clk_en low, no selection, pop or age change SHALL occur. Pushes and the read-return pipeline SHALL still advance.

Reset
REQ-015 While rst is high at a clk edge, the FIFO SHALL be flushed (count 0) and the age counter and owner tags cleared. Any in-flight read SHALL be discarded with no valid pulse.
REQ-016 During and after reset, all outputs SHALL be 0, except cpu_rdy = 1 from the first clk after reset deasserts.

Structure
REQ-017 The owner enum (vram_owner_t) and default DEPTH/STARVE_LIMIT constants SHALL live in the shared PPU defines package.
REQ-018 The FIFO SHALL be a sub-module, vram_req_fifo (parameter DEPTH, width 20, push/pop/full/empty/count). Arbitration, age logic and the return pipeline SHALL stay in vram_arb.

Verification
REQ-019 CPU write 0x5A to 0x123 with rendering=0 and ppu_clk_en=1 -> vram_we=1, addr 0x123, data 0x5A for exactly one clk; no valid pulse.
REQ-020 CPU read 0x040 while VRAM returns 0xC3 -> cpu_rd_valid pulses 2 clk after the selection edge with cpu_rd_data=0xC3; rend_rd_valid stays 0.
REQ-021 rendering=1, rend_req held high, one CPU write pending -> renderer is granted 8 consecutive enabled cycles, then the CPU write issues on the 9th; age returns to 0.
REQ-022 Push 5 requests back-to-back with DEPTH=4 and ppu_clk_en=0 -> cpu_rdy falls after the 4th push; the 5th is held; FIFO order is preserved once ppu_clk_en=1.
REQ-023 rst asserted 1 clk after a CPU read issues -> no cpu_rd_valid, count=0, vram strobes 0.
REQ-024 ppu_clk_en pulsed every 3rd clk with rend_req high -> rend_gnt only follows enabled edges; rend_rd_valid arrives 2 clk after each selection edge.
